// File: rtl/ctc_timing_scan_if.sv
// ctc_timing_scan_if: keycode handshake between the timing/scan block and the controller.
//   key_valid  producer -> consumer  a keycode is waiting in the output buffer
//   key_code   producer -> consumer  head keycode {row, col}, zero when empty
//   key_ovf    producer -> consumer  one-cycle pulse when a keycode was dropped
//   key_ack    consumer -> producer  consume the head keycode
// master = keycode producer (ctc_timing_scan), slave = controller side.
interface ctc_timing_scan_if #(
    parameter int CODE_W = 6
);
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_ovf;
    logic              key_ack;

    modport master (output key_valid, output key_code, output key_ovf, input key_ack);
    modport slave  (input key_valid, input key_code, input key_ovf, output key_ack);
endinterface

// File: rtl/ctc_timing_scan.sv
// ctc_timing_scan: control-and-timing block for the calculator core.
// Produces the word-time counter, the instruction-sync window, the
// pointer-relative word select and a debounced keyboard scanner.
// Ports:
//   cph2 / rst             clock (rising edge) and synchronous active-high reset
//   sync, word_end, digit  word timing outputs
//   ptr_ld, ptr_val        pointer load, taken only at word_end
//   ws_ld, ws_mode,
//   ws_lo, ws_hi           word-select mode/field load, taken only at word_end
//   ws                     word select for the current digit
//   kr / kc                one-hot row drive / active-high column sense
//   key_bus (master)       key_valid/key_code/key_ovf out, key_ack in
// Optional feature: define CTC_KEY_FIFO_EN for a 4-entry keycode FIFO;
// otherwise a single keycode register is used.
module ctc_timing_scan #(
    parameter int DIGITS    = 14,
    parameter int DBITS     = 4,
    parameter int IS_LEN    = 10,
    parameter int KROWS     = 8,
    parameter int KCOLS     = 5,
    parameter int DEB_SCANS = 2,
    localparam int PW  = $clog2(DIGITS),
    localparam int KRW = $clog2(KROWS),
    localparam int KCW = $clog2(KCOLS)
) (
    input  logic             cph2,
    input  logic             rst,
    output logic             sync,
    output logic             word_end,
    output logic [PW-1:0]    digit,
    input  logic             ptr_ld,
    input  logic [PW-1:0]    ptr_val,
    input  logic             ws_ld,
    input  logic [2:0]       ws_mode,
    input  logic [PW-1:0]    ws_lo,
    input  logic [PW-1:0]    ws_hi,
    output logic             ws,
    output logic [KROWS-1:0] kr,
    input  logic [KCOLS-1:0] kc,
    ctc_timing_scan_if.master key_bus
);
    localparam int T      = DIGITS * DBITS;
    localparam int CW     = $clog2(T);
    localparam int DB_W   = $clog2(DBITS);
    localparam int CODE_W = KRW + KCW;
    localparam int NW     = $clog2(DEB_SCANS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(T - 1);
    localparam logic [CW-1:0]  SYNC_LO  = CW'(T - IS_LEN - 1);
    localparam logic [CW-1:0]  SYNC_HI  = CW'(T - 2);
    localparam logic [KRW-1:0] ROW_LAST = KRW'(KROWS - 1);

    typedef enum logic [1:0] {K_IDLE, K_CONFIRM, K_HELD} key_state_t;

    logic [CW-1:0]     cnt;
    logic [PW-1:0]     ptr, lo, hi;
    logic [2:0]        mode;
    logic [KRW-1:0]    row;
    logic              scan_hit;
    logic [CODE_W-1:0] scan_code;
    logic [KCW-1:0]    col_sel;
    logic              row_hit, hit_now, scan_end;
    logic [CODE_W-1:0] code_now;
    key_state_t        state, state_nx;
    logic [CODE_W-1:0] cand, cand_nx;
    logic [NW-1:0]     deb_n, deb_n_nx;
    logic              report, pop, accept, ovf;

    // Word-time counter; the timing outputs decode straight from it.
    always_ff @(posedge cph2) begin
        if (rst || word_end) cnt <= '0;
        else                 cnt <= cnt + CW'(1);
    end

    assign word_end = (cnt == CNT_LAST);
    assign sync     = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);
    assign digit    = PW'(cnt >> DB_W);

    // Loads are only honoured on the last bit-time so a new pointer or mode
    // always applies to a whole word.
    always_ff @(posedge cph2) begin
        if (rst) begin
            ptr  <= '0;
            mode <= '0;
            lo   <= '0;
            hi   <= '0;
        end else if (word_end) begin
            if (ptr_ld) ptr <= ptr_val;
            if (ws_ld) begin
                mode <= ws_mode;
                lo   <= ws_lo;
                hi   <= ws_hi;
            end
        end
    end

    // Word select decode; an out-of-range pointer falls out naturally
    // because digit never exceeds DIGITS-1.
    always_comb begin
        ws = 1'b0;
        case (mode)
            3'd1:    ws = (digit == ptr);
            3'd2:    ws = (digit <= ptr);
            3'd3:    ws = 1'b1;
            3'd4:    ws = (lo <= hi) && (digit >= lo) && (digit <= hi);
            default: ws = 1'b0;
        endcase
    end

    // Row drive and lowest-pressed-column priority encode.
    always_comb begin
        kr      = '0;
        kr[row] = 1'b1;
        col_sel = '0;
        for (int c = KCOLS - 1; c >= 0; c--) begin
            if (kc[c]) col_sel = KCW'(c);
        end
    end

    // The hit seen so far in this scan wins over the current row, which
    // gives "lowest row, then lowest column" ordering.
    assign row_hit  = |kc;
    assign hit_now  = scan_hit | row_hit;
    assign code_now = scan_hit ? scan_code : {row, col_sel};
    assign scan_end = word_end && (row == ROW_LAST);

    // Row stepping and per-scan hit capture at each row-word end.
    always_ff @(posedge cph2) begin
        if (rst) begin
            row       <= '0;
            scan_hit  <= 1'b0;
            scan_code <= '0;
        end else if (word_end) begin
            row <= (row == ROW_LAST) ? '0 : row + KRW'(1);
            if (scan_end) begin
                scan_hit  <= 1'b0;
                scan_code <= '0;
            end else if (!scan_hit && row_hit) begin
                scan_hit  <= 1'b1;
                scan_code <= {row, col_sel};
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge cph2) begin
        if (rst) begin
            state <= K_IDLE;
            cand  <= '0;
            deb_n <= '0;
        end else begin
            state <= state_nx;
            cand  <= cand_nx;
            deb_n <= deb_n_nx;
        end
    end

    // Debounce decision, evaluated once per scan. HELD ignores any new key
    // until the keyboard has been quiet for a whole scan.
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        deb_n_nx = deb_n;
        report   = 1'b0;
        if (scan_end) begin
            case (state)
                K_IDLE: begin
                    if (hit_now) begin
                        cand_nx  = code_now;
                        deb_n_nx = NW'(1);
                        if (DEB_SCANS == 1) begin
                            report   = 1'b1;
                            state_nx = K_HELD;
                        end else begin
                            state_nx = K_CONFIRM;
                        end
                    end
                end
                K_CONFIRM: begin
                    if (hit_now && (code_now == cand)) begin
                        deb_n_nx = deb_n + NW'(1);
                        if (int'(deb_n) + 1 >= DEB_SCANS) begin
                            report   = 1'b1;
                            state_nx = K_HELD;
                        end
                    end else begin
                        state_nx = K_IDLE;
                    end
                end
                K_HELD: begin
                    if (!hit_now) state_nx = K_IDLE;
                end
                default: state_nx = K_IDLE;
            endcase
        end
    end

`ifdef CTC_KEY_FIFO_EN
    logic [CODE_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        count;

    assign pop    = (count != 3'd0) && key_bus.key_ack;
    assign accept = report && ((count != 3'd4) || pop);

    // Four-entry FIFO; a pop in the same cycle frees room for the push.
    always_ff @(posedge cph2) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= report && !accept;
            if (accept) begin
                fifo_mem[wr_ptr] <= code_now;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign key_bus.key_valid = (count != 3'd0);
    assign key_bus.key_code  = (count != 3'd0) ? fifo_mem[rd_ptr] : '0;
`else
    logic              buf_valid;
    logic [CODE_W-1:0] buf_code;

    assign pop    = buf_valid && key_bus.key_ack;
    assign accept = report && (!buf_valid || pop);

    // Single holding register; a same-cycle ack makes room for the report.
    always_ff @(posedge cph2) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_code  <= '0;
            ovf       <= 1'b0;
        end else begin
            ovf <= report && !accept;
            if (accept) begin
                buf_valid <= 1'b1;
                buf_code  <= code_now;
            end else if (pop) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign key_bus.key_valid = buf_valid;
    assign key_bus.key_code  = buf_valid ? buf_code : '0;
`endif

    assign key_bus.key_ovf = ovf;
endmodule
